// File: rtl/user_id_capture.sv
// Qualifies the tie-cell project ID over several identical samples, latches it, compares it
// against the expected ID and serves ID/status bytes through a registered read port.
module user_id_capture #(
  parameter logic [31:0] USER_PROJECT_ID = 32'h0,
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned MAX_RETRY       = 3
) (
`ifdef USE_POWER_PINS
  inout  wire         VDD,
  inout  wire         VSS,
`endif
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] mask_rev,
  input  logic        recapture,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_ack,
  output logic [31:0] id_value,
  output logic        id_valid,
  output logic        id_error,
  output logic        id_mismatch
);

  typedef enum logic [1:0] {
    SAMPLE = 2'd0,
    DONE   = 2'd1,
    FAIL   = 2'd2
  } state_e;

  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_e      state_q,      state_d;
  logic [31:0] prev_q,       prev_d;
  logic [3:0]  stableCnt_q,  stableCnt_d;
  logic [3:0]  retryCnt_q,   retryCnt_d;
  logic        primed_q,     primed_d;
  logic [31:0] idValue_q,    idValue_d;
  logic        idValid_q,    idValid_d;
  logic        idError_q,    idError_d;
  logic        idMismatch_q, idMismatch_d;
  logic [7:0]  rdData_q,     rdData_d;
  logic        rdAck_q,      rdAck_d;
  logic [3:0]  retryNext;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= SAMPLE;
      prev_q       <= 32'h0;
      stableCnt_q  <= 4'h0;
      retryCnt_q   <= 4'h0;
      primed_q     <= 1'b0;
      idValue_q    <= 32'h0;
      idValid_q    <= 1'b0;
      idError_q    <= 1'b0;
      idMismatch_q <= 1'b0;
      rdData_q     <= 8'h00;
      rdAck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      stableCnt_q  <= stableCnt_d;
      retryCnt_q   <= retryCnt_d;
      primed_q     <= primed_d;
      idValue_q    <= idValue_d;
      idValid_q    <= idValid_d;
      idError_q    <= idError_d;
      idMismatch_q <= idMismatch_d;
      rdData_q     <= rdData_d;
      rdAck_q      <= rdAck_d;
    end
  end

  // Reads mux the current registers, so a read on a capture edge sees pre-update contents.
  always_comb begin
    rdAck_d  = rd_en;
    rdData_d = rdData_q;
    if (rd_en) begin
      case (rd_addr)
        3'd0:    rdData_d = idValue_q[7:0];
        3'd1:    rdData_d = idValue_q[15:8];
        3'd2:    rdData_d = idValue_q[23:16];
        3'd3:    rdData_d = idValue_q[31:24];
        3'd4:    rdData_d = {5'b0, idMismatch_q, idError_q, idValid_q};
        default: rdData_d = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    stableCnt_d  = stableCnt_q;
    retryCnt_d   = retryCnt_q;
    primed_d     = primed_q;
    idValue_d    = idValue_q;
    idValid_d    = idValid_q;
    idError_d    = idError_q;
    idMismatch_d = idMismatch_q;
    retryNext    = (retryCnt_q == 4'hF) ? retryCnt_q : retryCnt_q + 4'd1;

    if (recapture) begin
      state_d      = SAMPLE;
      stableCnt_d  = 4'h0;
      retryCnt_d   = 4'h0;
      primed_d     = 1'b0;
      idValid_d    = 1'b0;
      idError_d    = 1'b0;
      idMismatch_d = 1'b0;
    end else begin
      case (state_q)
        SAMPLE: begin
          prev_d = mask_rev;
          // The first sample after reset or recapture only seeds prev.
          if (!primed_q) begin
            primed_d = 1'b1;
          end else if (mask_rev == prev_q) begin
            if (stableCnt_q >= STABLE_LAST) begin
              idValue_d    = mask_rev;
              idValid_d    = 1'b1;
              idMismatch_d = (mask_rev != USER_PROJECT_ID);
              state_d      = DONE;
            end else if (stableCnt_q != 4'hF) begin
              stableCnt_d = stableCnt_q + 4'd1;
            end
          end else begin
            stableCnt_d = 4'h0;
            retryCnt_d  = retryNext;
            if (retryNext >= RETRY_LIMIT) begin
              idValue_d = mask_rev;
              idError_d = 1'b1;
              state_d   = FAIL;
            end
          end
        end
        DONE:    state_d = DONE;
        FAIL:    state_d = FAIL;
        default: state_d = SAMPLE;
      endcase
    end
  end

  assign rd_data     = rdData_q;
  assign rd_ack      = rdAck_q;
  assign id_value    = idValue_q;
  assign id_valid    = idValid_q;
  assign id_error    = idError_q;
  assign id_mismatch = idMismatch_q;

endmodule

// File: tb/tb_user_id_capture.sv
// Directed, table-driven bench for user_id_capture: qualification, mismatch, failure,
// recapture, byte reads and synchronous reset.
module tb_user_id_capture;

  localparam logic [31:0] PID    = 32'hA5C3_0F12;
  localparam int          STABLE = 4;
  localparam int          RETRY  = 3;
  localparam logic [31:0] A      = 32'hA5C3_0F12;
  localparam logic [31:0] D      = 32'hDEAD_BEEF;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [31:0] mask_rev = 32'h0;
  logic        recapture = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic [7:0]  rd_data;
  logic        rd_ack;
  logic [31:0] id_value;
  logic        id_valid;
  logic        id_error;
  logic        id_mismatch;

  int checks   = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  user_id_capture #(
    .USER_PROJECT_ID(PID),
    .STABLE_CYCLES  (STABLE),
    .MAX_RETRY      (RETRY)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .mask_rev   (mask_rev),
    .recapture  (recapture),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ack     (rd_ack),
    .id_value   (id_value),
    .id_valid   (id_valid),
    .id_error   (id_error),
    .id_mismatch(id_mismatch)
  );

  typedef struct {
    logic        rst;
    logic        recap;
    logic [31:0] mask;
    logic        en;
    logic [2:0]  addr;
    logic        expValid;
    logic        expError;
    logic        expMismatch;
    logic [31:0] expValue;
    logic        expAck;
    logic [7:0]  expData;
  } vec_t;

  vec_t vecs[25];

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the following edge.
  task automatic applyStimulus(input logic rst, input logic recap, input logic [31:0] mask,
                               input logic en, input logic [2:0] addr);
    wb_rst_i  = rst;
    recapture = recap;
    mask_rev  = mask;
    rd_en     = en;
    rd_addr   = addr;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic e, input logic m,
                             input logic [31:0] val, input logic ack, input logic [7:0] data);
    checkVal({tag, ".id_valid"},    {31'b0, id_valid},    {31'b0, v});
    checkVal({tag, ".id_error"},    {31'b0, id_error},    {31'b0, e});
    checkVal({tag, ".id_mismatch"}, {31'b0, id_mismatch}, {31'b0, m});
    checkVal({tag, ".id_value"},    id_value,             val);
    checkVal({tag, ".rd_ack"},      {31'b0, rd_ack},      {31'b0, ack});
    checkVal({tag, ".rd_data"},     {24'b0, rd_data},     {24'b0, data});
  endtask

  initial begin
    int n;
    logic [31:0] tog;

    vecs[0]  = '{1'b1, 1'b0, A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, A, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, A, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'h12};
    vecs[7]  = '{1'b0, 1'b0, A, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'h0F};
    vecs[8]  = '{1'b0, 1'b0, A, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'hC3};
    vecs[9]  = '{1'b0, 1'b0, A, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'hA5};
    vecs[10] = '{1'b0, 1'b0, A, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'h01};
    vecs[11] = '{1'b0, 1'b0, A, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'h00};
    vecs[12] = '{1'b0, 1'b0, A, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'h00};
    vecs[13] = '{1'b0, 1'b0, A, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'h00};
    vecs[14] = '{1'b0, 1'b0, D, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, A,     1'b1, 8'hA5};
    vecs[15] = '{1'b0, 1'b0, D, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, A,     1'b0, 8'hA5};
    vecs[16] = '{1'b0, 1'b1, D, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, A,     1'b0, 8'hA5};
    vecs[17] = '{1'b0, 1'b0, D, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, A,     1'b0, 8'hA5};
    vecs[18] = '{1'b0, 1'b0, D, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, A,     1'b0, 8'hA5};
    vecs[19] = '{1'b0, 1'b0, D, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, A,     1'b0, 8'hA5};
    vecs[20] = '{1'b0, 1'b0, D, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, A,     1'b0, 8'hA5};
    vecs[21] = '{1'b0, 1'b0, D, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, D,     1'b0, 8'hA5};
    vecs[22] = '{1'b0, 1'b0, D, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, D,     1'b1, 8'h05};
    vecs[23] = '{1'b0, 1'b0, D, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, D,     1'b1, 8'hEF};
    vecs[24] = '{1'b0, 1'b0, D, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, D,     1'b1, 8'hDE};

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].recap, vecs[i].mask, vecs[i].en, vecs[i].addr);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expError,
                  vecs[i].expMismatch, vecs[i].expValue, vecs[i].expAck, vecs[i].expData);
    end

    // Toggling ID: three mismatches after the seed sample push the FSM into FAIL.
    applyStimulus(1'b0, 1'b1, 32'h1, 1'b0, 3'd0);
    checkOutput("failRecap", 1'b0, 1'b0, 1'b0, D, 1'b0, 8'hDE);
    applyStimulus(1'b0, 1'b0, 32'h2, 1'b0, 3'd0);
    checkOutput("failSeed", 1'b0, 1'b0, 1'b0, D, 1'b0, 8'hDE);
    applyStimulus(1'b0, 1'b0, 32'h1, 1'b0, 3'd0);
    checkOutput("failRetry1", 1'b0, 1'b0, 1'b0, D, 1'b0, 8'hDE);
    applyStimulus(1'b0, 1'b0, 32'h2, 1'b0, 3'd0);
    checkOutput("failRetry2", 1'b0, 1'b0, 1'b0, D, 1'b0, 8'hDE);
    applyStimulus(1'b0, 1'b0, 32'h1, 1'b0, 3'd0);
    checkOutput("failEnter", 1'b0, 1'b1, 1'b0, 32'h1, 1'b0, 8'hDE);
    for (int i = 0; i < 4; i++) begin
      tog = (i % 2 == 0) ? 32'h2 : 32'h1;
      applyStimulus(1'b0, 1'b0, tog, 1'b0, 3'd0);
      checkOutput($sformatf("failHold%0d", i), 1'b0, 1'b1, 1'b0, 32'h1, 1'b0, 8'hDE);
    end
    applyStimulus(1'b0, 1'b0, 32'h2, 1'b1, 3'd4);
    checkOutput("failStatus", 1'b0, 1'b1, 1'b0, 32'h1, 1'b1, 8'h02);

    // Reset lands mid-qualification with a read request on the same edge.
    applyStimulus(1'b0, 1'b1, 32'h7, 1'b0, 3'd0);
    checkOutput("rstRecap", 1'b0, 1'b0, 1'b0, 32'h1, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b0, 32'h7, 1'b1, 3'd0);
    checkOutput("rstPreRead", 1'b0, 1'b0, 1'b0, 32'h1, 1'b1, 8'h01);
    applyStimulus(1'b1, 1'b0, 32'h7, 1'b1, 3'd0);
    checkOutput("rstEdge", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);

    n = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, A, 1'b0, 3'd0);
      n++;
      if (i == 0) checkVal("rstNoAck", {31'b0, rd_ack}, 32'h0);
      if (id_valid) break;
    end
    checkVal("rstLatency", n, STABLE + 1);
    checkVal("rstValue", id_value, A);
    checkVal("rstMismatch", {31'b0, id_mismatch}, 32'h0);
    checkVal("rstError", {31'b0, id_error}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
